// File: rtl/sram_arbiter.sv
// Two-to-one arbiter sharing one 64-bit synchronous SRAM between instruction fetch and load/store.
// Optional starvation guard for the instruction side: define ARB_STARVE_GUARD_EN.
module sram_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        inst_req,
  input  logic [3:0]  inst_wen,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic [7:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [63:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [63:0] data_rdata,

  output logic        mem_en,
  output logic [7:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  // Handshake: a requester holds req/addr/wen/wdata until gnt is sampled high;
  // gnt is combinational, and exactly one rvalid follows each gnt one cycle later.

  localparam logic OWNER_DATA = 1'b0;
  localparam logic OWNER_INST = 1'b1;

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("sram_arbiter: STARVE_MAX must be in 1..15");
  end

  logic inst_wins;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign inst_wins = (starve_cnt >= 4'(STARVE_MAX));

  // Counts cycles the instruction side waited; saturates so it never wraps back to losing.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (inst_gnt) begin
      starve_cnt <= 4'd0;
    end else if (inst_req && (starve_cnt != 4'hF)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign inst_wins = 1'b0;
`endif

  // No grants at all during reset so a pending request cannot slip through.
  assign data_gnt = !reset && data_req && !(inst_req && inst_wins);
  assign inst_gnt = !reset && inst_req && (!data_req || inst_wins);
  assign mem_en   = inst_gnt | data_gnt;

  always_comb begin
    mem_wen   = 8'h00;
    mem_addr  = 32'h0;
    mem_wdata = 64'h0;
    if (data_gnt) begin
      mem_wen   = data_wen;
      mem_addr  = {data_addr[31:3], 3'b000};
      mem_wdata = data_wdata;
    end else if (inst_gnt) begin
      mem_wen   = inst_addr[2] ? {inst_wen, 4'h0} : {4'h0, inst_wen};
      mem_addr  = {inst_addr[31:3], 3'b000};
      mem_wdata = {inst_wdata, inst_wdata};
    end
  end

  logic resp_v;
  logic owner;
  logic lane;

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_v <= 1'b0;
      owner  <= OWNER_DATA;
      lane   <= 1'b0;
    end else begin
      resp_v <= mem_en;
      if (mem_en) begin
        owner <= inst_gnt ? OWNER_INST : OWNER_DATA;
        lane  <= inst_gnt ? inst_addr[2] : 1'b0;
      end
    end
  end

  assign data_rvalid = resp_v && (owner == OWNER_DATA);
  assign inst_rvalid = resp_v && (owner == OWNER_INST);
  assign data_rdata  = mem_rdata;
  assign inst_rdata  = lane ? mem_rdata[63:32] : mem_rdata[31:0];

  // Sub-word address bits are irrelevant to the 8-byte-aligned memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr[1:0], data_addr[2:0]};

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table, multi-cycle corner sequences
// and a randomized pipelined phase against a shadow memory and response scoreboard.
module tb_sram_arbiter;

  localparam int unsigned STARVE_MAX = 4;

  logic        clock;
  logic        reset;
  logic        inst_req;
  logic [3:0]  inst_wen;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [7:0]  data_wen;
  logic [31:0] data_addr;
  logic [63:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [63:0] data_rdata;
  logic        mem_en;
  logic [7:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  sram_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clock      (clock),
    .reset      (reset),
    .inst_req   (inst_req),
    .inst_wen   (inst_wen),
    .inst_addr  (inst_addr),
    .inst_wdata (inst_wdata),
    .inst_gnt   (inst_gnt),
    .inst_rvalid(inst_rvalid),
    .inst_rdata (inst_rdata),
    .data_req   (data_req),
    .data_wen   (data_wen),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_gnt   (data_gnt),
    .data_rvalid(data_rvalid),
    .data_rdata (data_rdata),
    .mem_en     (mem_en),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- backing memory ----------------
  logic        use_model;
  logic [63:0] tbl_rdata;
  logic [63:0] mem_q;
  logic [63:0] mem [16];

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 64'h0;
      mem_q <= 64'h0;
    end else if (mem_en) begin
      mem_q <= mem[mem_addr[6:3]];
      for (int b = 0; b < 8; b++)
        if (mem_wen[b]) mem[mem_addr[6:3]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  assign mem_rdata = use_model ? mem_q : tbl_rdata;

  // ---------------- scoreboard state ----------------
  int pass_cnt = 0;
  int total_cnt = 0;

  // entry: {owner(1=inst), is_read, expected read data}
  logic [65:0] exp_q[$];
  logic [63:0] shadow [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    inst_req = 1'b0; inst_wen = 4'h0; inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 1'b0; data_wen = 8'h0; data_addr = 32'h0; data_wdata = 64'h0;
    tbl_rdata = 64'h0;
  endtask

  typedef struct packed {
    logic        ireq;
    logic [3:0]  iwen;
    logic [31:0] iaddr;
    logic [31:0] iwdata;
    logic        dreq;
    logic [7:0]  dwen;
    logic [31:0] daddr;
    logic [63:0] dwdata;
    logic [63:0] rdata;
    logic        e_igt;
    logic        e_dgt;
    logic [7:0]  e_mwen;
    logic [31:0] e_maddr;
    logic [63:0] e_mwdata;
    logic        e_irv;
    logic        e_drv;
    logic        e_rdchk;
    logic [31:0] e_irdata;
    logic [63:0] e_drdata;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  task automatic apply_vec(input vec_t v, input int n);
    inst_req = v.ireq; inst_wen = v.iwen; inst_addr = v.iaddr; inst_wdata = v.iwdata;
    data_req = v.dreq; data_wen = v.dwen; data_addr = v.daddr; data_wdata = v.dwdata;
    tbl_rdata = v.rdata;
    #1;
    check($sformatf("v%0d_inst_gnt", n), 64'(inst_gnt), 64'(v.e_igt));
    check($sformatf("v%0d_data_gnt", n), 64'(data_gnt), 64'(v.e_dgt));
    check($sformatf("v%0d_mem_en", n), 64'(mem_en), 64'(v.e_igt | v.e_dgt));
    check($sformatf("v%0d_mem_wen", n), 64'(mem_wen), 64'(v.e_mwen));
    check($sformatf("v%0d_mem_addr", n), 64'(mem_addr), 64'(v.e_maddr));
    check($sformatf("v%0d_mem_wdata", n), mem_wdata, v.e_mwdata);
    check($sformatf("v%0d_inst_rvalid", n), 64'(inst_rvalid), 64'(v.e_irv));
    check($sformatf("v%0d_data_rvalid", n), 64'(data_rvalid), 64'(v.e_drv));
    if (v.e_rdchk && v.e_irv) check($sformatf("v%0d_inst_rdata", n), 64'(inst_rdata), 64'(v.e_irdata));
    if (v.e_rdchk && v.e_drv) check($sformatf("v%0d_data_rdata", n), data_rdata, v.e_drdata);
  endtask

  task automatic fill_vectors();
    for (int i = 0; i < NVEC; i++) vecs[i] = '0;
    // single instruction read, upper lane
    vecs[1].ireq = 1'b1; vecs[1].iaddr = 32'h8000_0004;
    vecs[1].e_igt = 1'b1; vecs[1].e_maddr = 32'h8000_0000;
    vecs[2].rdata = 64'h1111_2222_3333_4444;
    vecs[2].e_irv = 1'b1; vecs[2].e_rdchk = 1'b1; vecs[2].e_irdata = 32'h1111_2222;
    // instruction write steered to upper lane
    vecs[3].ireq = 1'b1; vecs[3].iwen = 4'hF; vecs[3].iaddr = 32'h8000_0004; vecs[3].iwdata = 32'hDEAD_BEEF;
    vecs[3].e_igt = 1'b1; vecs[3].e_mwen = 8'hF0; vecs[3].e_maddr = 32'h8000_0000;
    vecs[3].e_mwdata = 64'hDEAD_BEEF_DEAD_BEEF;
    // contention: data wins, inst stays pending
    vecs[4].ireq = 1'b1; vecs[4].iaddr = 32'h2000_0000;
    vecs[4].dreq = 1'b1; vecs[4].daddr = 32'h1000_000F; vecs[4].dwdata = 64'h0123_4567_89AB_CDEF;
    vecs[4].e_dgt = 1'b1; vecs[4].e_maddr = 32'h1000_0008; vecs[4].e_mwdata = 64'h0123_4567_89AB_CDEF;
    vecs[4].e_irv = 1'b1;
    vecs[5].ireq = 1'b1; vecs[5].iaddr = 32'h2000_0000; vecs[5].rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    vecs[5].e_igt = 1'b1; vecs[5].e_maddr = 32'h2000_0000;
    vecs[5].e_drv = 1'b1; vecs[5].e_rdchk = 1'b1; vecs[5].e_drdata = 64'hAAAA_BBBB_CCCC_DDDD;
    // data partial write while inst read (lower lane) returns
    vecs[6].dreq = 1'b1; vecs[6].dwen = 8'h0F; vecs[6].daddr = 32'h3000_0010;
    vecs[6].dwdata = 64'hCAFE_F00D_1234_5678; vecs[6].rdata = 64'h5555_6666_7777_8888;
    vecs[6].e_dgt = 1'b1; vecs[6].e_mwen = 8'h0F; vecs[6].e_maddr = 32'h3000_0010;
    vecs[6].e_mwdata = 64'hCAFE_F00D_1234_5678;
    vecs[6].e_irv = 1'b1; vecs[6].e_rdchk = 1'b1; vecs[6].e_irdata = 32'h7777_8888;
    // inst read at unaligned-to-8 word, back to back with the data write response
    vecs[7].ireq = 1'b1; vecs[7].iaddr = 32'h4000_000C;
    vecs[7].e_igt = 1'b1; vecs[7].e_maddr = 32'h4000_0008; vecs[7].e_drv = 1'b1;
    vecs[8].rdata = 64'h9999_AAAA_BBBB_CCCC;
    vecs[8].e_irv = 1'b1; vecs[8].e_rdchk = 1'b1; vecs[8].e_irdata = 32'h9999_AAAA;
  endtask

  // ---------------- test ----------------
  logic ipend, dpend, exp_ig, exp_dg, inst_wins_m;
  int   starve_m;
  logic [65:0] ent;

  initial begin
    use_model = 1'b0;
    drive_idle();
    fill_vectors();

    // reset with requests present: nothing may be granted
    reset = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h8000_0004; data_req = 1'b1; data_addr = 32'h1000_0008;
    data_wen = 8'hFF; data_wdata = 64'h1;
    @(negedge clock); #1;
    check("rst_inst_gnt", 64'(inst_gnt), 64'h0);
    check("rst_data_gnt", 64'(data_gnt), 64'h0);
    check("rst_mem_en", 64'(mem_en), 64'h0);
    check("rst_mem_wen", 64'(mem_wen), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_mem_wdata", mem_wdata, 64'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      apply_vec(vecs[i], i);
      @(negedge clock);
    end

    // starvation: data_req held, inst_req held
    drive_idle();
    inst_req = 1'b1; inst_addr = 32'h0000_0040; data_req = 1'b1;
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 10; k++) begin
      data_addr = 32'(k * 8);
      #1;
      check($sformatf("starve%0d_inst_gnt", k), 64'(inst_gnt), 64'((k % 5) == 4));
      check($sformatf("starve%0d_data_gnt", k), 64'(data_gnt), 64'((k % 5) != 4));
      @(negedge clock);
    end
`else
    for (int k = 0; k < 20; k++) begin
      data_addr = 32'(k * 8);
      #1;
      check($sformatf("starve%0d_inst_gnt", k), 64'(inst_gnt), 64'h0);
      check($sformatf("starve%0d_data_gnt", k), 64'(data_gnt), 64'h1);
      @(negedge clock);
    end
`endif

    // reset mid-stream: grant data in c0, reset in c1 with both reqs high
    drive_idle();
    @(negedge clock);
    data_req = 1'b1; data_addr = 32'h0000_0018;
    #1;
    check("rms_c0_data_gnt", 64'(data_gnt), 64'h1);
    @(negedge clock);
    reset = 1'b1; inst_req = 1'b1; inst_addr = 32'h0000_0020;
    #1;
    check("rms_c1_data_rvalid", 64'(data_rvalid), 64'h1);
    check("rms_c1_inst_gnt", 64'(inst_gnt), 64'h0);
    check("rms_c1_data_gnt", 64'(data_gnt), 64'h0);
    check("rms_c1_mem_en", 64'(mem_en), 64'h0);
    @(negedge clock);
    reset = 1'b0; drive_idle();
    #1;
    check("rms_c2_data_rvalid", 64'(data_rvalid), 64'h0);
    check("rms_c2_inst_rvalid", 64'(inst_rvalid), 64'h0);

    // randomized pipelined traffic against shadow memory and response queue
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    use_model = 1'b1;
    for (int i = 0; i < 16; i++) shadow[i] = 64'h0;
    exp_q.delete();
    ipend = 1'b0; dpend = 1'b0; starve_m = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clock);
      if (!ipend && $urandom_range(0, 1) == 1) begin
        ipend = 1'b1;
        inst_wen   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        inst_addr  = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
        inst_wdata = $urandom;
      end
      if (!dpend && $urandom_range(0, 2) != 0) begin
        dpend = 1'b1;
        data_wen   = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h0;
        data_addr  = {25'h0, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
        data_wdata = {$urandom, $urandom};
      end
      inst_req = ipend;
      data_req = dpend;
      #1;
`ifdef ARB_STARVE_GUARD_EN
      inst_wins_m = (starve_m >= int'(STARVE_MAX));
`else
      inst_wins_m = 1'b0;
`endif
      exp_dg = dpend && !(ipend && inst_wins_m);
      exp_ig = ipend && !exp_dg;
      check("rnd_inst_gnt", 64'(inst_gnt), 64'(exp_ig));
      check("rnd_data_gnt", 64'(data_gnt), 64'(exp_dg));
      check("rnd_mem_en", 64'(mem_en), 64'(inst_gnt | data_gnt));

      check("rnd_rvalid", 64'(inst_rvalid | data_rvalid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        ent = exp_q.pop_front();
        check("rnd_owner", 64'({inst_rvalid, data_rvalid}), 64'({ent[65], !ent[65]}));
        if (ent[64]) begin
          if (ent[65]) check("rnd_inst_rdata", 64'(inst_rdata), 64'(ent[31:0]));
          else         check("rnd_data_rdata", data_rdata, ent[63:0]);
        end
      end

      if (exp_ig) begin
        if (inst_wen == 4'h0) begin
          exp_q.push_back({1'b1, 1'b1, 32'h0,
                           inst_addr[2] ? shadow[inst_addr[6:3]][63:32] : shadow[inst_addr[6:3]][31:0]});
        end else begin
          for (int b = 0; b < 4; b++)
            if (inst_wen[b])
              shadow[inst_addr[6:3]][(inst_addr[2] ? 32 : 0) + b*8 +: 8] = inst_wdata[b*8 +: 8];
          exp_q.push_back({1'b1, 1'b0, 64'h0});
        end
        ipend = 1'b0;
      end
      if (exp_dg) begin
        if (data_wen == 8'h0) begin
          exp_q.push_back({1'b0, 1'b1, shadow[data_addr[6:3]]});
        end else begin
          for (int b = 0; b < 8; b++)
            if (data_wen[b]) shadow[data_addr[6:3]][b*8 +: 8] = data_wdata[b*8 +: 8];
          exp_q.push_back({1'b0, 1'b0, 64'h0});
        end
        dpend = 1'b0;
      end

      if (exp_ig) starve_m = 0;
      else if (ipend && starve_m < 15) starve_m++;
    end

    // drain: the last grant still owes one response
    @(negedge clock);
    drive_idle();
    #1;
    check("drain_rvalid", 64'(inst_rvalid | data_rvalid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      ent = exp_q.pop_front();
      check("drain_owner", 64'({inst_rvalid, data_rvalid}), 64'({ent[65], !ent[65]}));
    end
    @(negedge clock); #1;
    check("drain_idle_rvalid", 64'(inst_rvalid | data_rvalid), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-to-one arbiter sharing a single 64-bit synchronous SRAM between the core's instruction-fetch and load/store requesters. It sits between PuaCpu's memory interfaces and the unified memory model, so the testbench needs only one backing memory. The block grants one access per cycle, routes the fixed one-cycle read response back to the requester that owns it, and adapts 32-bit instruction accesses onto the 64-bit memory lanes.

## Interface
- `STARVE_MAX`, 4, the number of consecutive lost arbitration cycles after which the instruction side wins. Legal range is 1..15. Used only with `ARB_STARVE_GUARD_EN`.
- `clock` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous reset, active-high.
- `inst_req` in 1: instruction-side access request.
- `inst_wen` in 4: instruction-side byte write enables; 0 means read.
- `inst_addr` in 32: instruction-side byte address.
- `inst_wdata` in 32: instruction-side write data.
- `inst_gnt` out 1: the instruction access is accepted this cycle.
- `inst_rvalid` out 1: instruction-side response valid.
- `inst_rdata` out 32: instruction-side read data.
- `data_req` in 1: data-side access request.
- `data_wen` in 8: data-side byte write enables; 0 means read.
- `data_addr` in 32: data-side byte address.
- `data_wdata` in 64: data-side write data.
- `data_gnt` out 1: the data access is accepted this cycle.
- `data_rvalid` out 1: data-side response valid.
- `data_rdata` out 64: data-side read data.
- `mem_en` out 1: memory access strobe.
- `mem_wen` out 8: memory byte write enables.
- `mem_addr` out 32: memory address, 8-byte aligned.
- `mem_wdata` out 64: memory write data.
- `mem_rdata` in 64: memory read data, valid one cycle after `mem_en`.

## Operation
- **Request rule:** a requester holds req, addr, wen and wdata stable until its gnt is sampled high. Dropping req before gnt is permitted and abandons the request.
- **Grant:** gnt is combinational from req and the arbiter state.
  - At most one gnt is high per cycle.
  - `mem_en` = `inst_gnt` | `data_gnt`.
  - A single requester is granted immediately.
- **Contention:** data wins by default (see Configuration).
- **Data grant:**
  - `mem_addr` = {`data_addr`[31:3], 3'b0}.
  - `mem_wen` = `data_wen`.
  - `mem_wdata` = `data_wdata`.
- **Instruction grant:**
  - `mem_addr` = {`inst_addr`[31:3], 3'b0}.
  - Lane = `inst_addr`[2]. `mem_wen` = lane ? {`inst_wen`, 4'h0} : {4'h0, `inst_wen`}.
  - `mem_wdata` = {`inst_wdata`, `inst_wdata`}.
- **Idle bus:** with no grant, `mem_en`=0, `mem_wen`=0, `mem_addr`=0 and `mem_wdata`=0.
- **Response registers:** `owner` (1 bit), `lane` (1 bit), `resp_v` (1 bit), latched at every grant.
- **Responses:** every granted access, read or write, yields exactly one rvalid, in order.
  - `data_rvalid` = `resp_v` & (`owner` == data).
  - `inst_rvalid` = `resp_v` & (`owner` == inst).
  - `data_rdata` = `mem_rdata`.
  - `inst_rdata` = `lane` ? `mem_rdata`[63:32] : `mem_rdata`[31:0].
  - rdata is defined only while the matching rvalid is high; for writes rdata is don't-care.
- **Reset values:**
  - All gnt, `mem_en`, `mem_wen`, `mem_addr` and `mem_wdata` are 0 while `reset`=1.
  - `resp_v`=0, `owner`=data, `lane`=0, starvation counter=0.
  - Both rvalids read 0 in the cycle after a reset cycle.

## Timing
- Grant latency is 0 cycles.
- Response latency: rvalid is high exactly 1 cycle after the gnt cycle.
- Throughput is one access per cycle in total. Back-to-back grants to the same or alternating requesters are legal. A requester may present a new req in the same cycle its rvalid is high.
- **Simultaneous requests:** in the contested cycle only one side is granted; the loser's req remains pending.
- **Reset asserted in cycle c:**
  - A req pending in c is not granted.
  - A grant made in cycle c−1 still shows its rvalid in cycle c.
  - The registers are cleared at the end of c.

## Configuration
- Macro: `ARB_STARVE_GUARD_EN`.
- **Defined:**
  - A 4-bit counter increments each cycle that `inst_req`=1 and `inst_gnt`=0, and clears on `inst_gnt` or reset.
  - When counter ≥ `STARVE_MAX`, the instruction side wins contention.
  - The counter saturates at 15.
- **Undefined:**
  - Strict data priority; no counter exists.
  - The instruction side can starve indefinitely under continuous `data_req`.

## Test plan
- **Single instruction read:** `inst_req`=1, `inst_addr`=0x8000_0004, `mem_rdata`=0x1111_2222_3333_4444 → `inst_gnt`=1 and `mem_addr`=0x8000_0000 in the same cycle; next cycle `inst_rvalid`=1 and `inst_rdata`=0x1111_2222.
- **Instruction write lane steering:** `inst_wen`=4'hF, `inst_addr`=0x8000_0004, `inst_wdata`=0xDEAD_BEEF → `mem_wen`=8'hF0 and `mem_wdata`=0xDEAD_BEEF_DEAD_BEEF; `inst_rvalid` is high one cycle later.
- **Contention:** both req high for one cycle → `data_gnt`=1 and `inst_gnt`=0; next cycle `data_rvalid`=1 and `inst_gnt`=1 (data req dropped); the following cycle `inst_rvalid`=1.
- **Starvation guard:** with `ARB_STARVE_GUARD_EN` and `STARVE_MAX`=4, `data_req` held high with `inst_req`=1 → data granted for 4 cycles, `inst_gnt` in the 5th, then data again. Without the macro, `inst_gnt` stays 0 for 20 cycles.
- **Reset mid-stream:** grant data in cycle 0 and assert reset in cycle 1 with both reqs high → `data_rvalid`=1 in cycle 1, no gnt in cycle 1, both rvalids 0 in cycle 2.
- **Randomized pipelined traffic:** 1000 cycles against a scoreboard → every gnt is matched by exactly one rvalid to the same requester, in order, and `mem_en` equals the OR of the gnts.
